alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the EX-stage operand path (port 0) and the branch-compare / address-calc path (port 1).
- Each requester uses a valid/ready handshake. The arbiter picks one request per cycle using round-robin.
- It drives the external ALU inputs and captures the ALU result and zero flag into a one-entry response register with its own valid/ready handshake.
- It sits between the forwarding muxes and the ALU in the pipelined datapath.

Parameters:
- WIDTH, 32, operand and result width.
- CTRL_W, 3, ALU control code width (000 add, 001 sub, 010 and, 011 or, 101 slt; other codes give result 0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  bit n: requester n presents an operation.
- req_ready  output  2  bit n: requester n's operation is accepted this cycle.
- req0_src1, req0_src2  input  WIDTH  requester 0 operands.
- req0_control  input  CTRL_W  requester 0 ALU code.
- req1_src1, req1_src2  input  WIDTH  requester 1 operands.
- req1_control  input  CTRL_W  requester 1 ALU code.
- alu_src1, alu_src2  output  WIDTH  operands driven to the ALU.
- alu_control  output  CTRL_W  code driven to the ALU.
- alu_result  input  WIDTH  ALU result (combinational from alu_* outputs).
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  1  requester index the response belongs to.
- rsp_result  output  WIDTH  registered ALU result.
- rsp_zero  output  1  registered zero flag.

Behaviour:
- Reset (synchronous, takes effect at the next rising edge with reset=1):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, last_grant=1 (so requester 0 wins the first tie).
  - Any in-flight response is discarded.
  - req_ready=00 while reset is high.
- Slot free:
  - slot_free = !rsp_valid | rsp_ready (same-cycle drain allows back-to-back accepts).
- Grant (combinational, only when slot_free):
  - Only one req_valid set: grant that requester.
  - Both set: grant the requester != last_grant.
  - None set: no grant.
- req_ready:
  - req_ready[n] = slot_free & grant==n. At most one bit is high per cycle.
  - req_ready never depends on payload values.
- ALU drive:
  - alu_src1/alu_src2/alu_control are muxed from the granted requester.
  - With no grant they hold requester 0's inputs; this is don't-care but must be deterministic (no X).
- Accept (req_valid[n] & req_ready[n]):
  - At the next edge: rsp_valid<=1, rsp_id<=n, rsp_result<=alu_result, rsp_zero<=alu_zero, last_grant<=n.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Response drain:
  - rsp_valid & rsp_ready with no new accept: rsp_valid<=0. Data registers hold their last value.
  - Drain and accept in the same cycle: the register is overwritten with the new response, and rsp_valid stays 1.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0 forces req_ready=00.
  - The response register holds steady, with no change in any rsp_* output.
- Requester rules:
  - Once req_valid[n] is asserted, payload and valid must stay stable until accepted.
  - The arbiter does not check this rule. The bench asserts it.
- Fairness:
  - With both requesters valid continuously and rsp_ready=1, grants alternate every cycle: 0,1,0,1…
  - Neither requester waits more than 1 accept of the other.
- rsp_zero reflects the ALU flag, so undefined codes produce result 0 and zero 1.

Optional Feature:
- Macro: ALU_SHARE_LOCK_EN.
- With it defined:
  - Adds input port req_lock (2 bits) and a lock_owner/locked register pair. Both registers reset to 0.
  - On accepting requester n with req_lock[n]=1, the arbiter sets locked<=1 and lock_owner<=n.
  - While locked, only lock_owner can be granted; the other requester sees req_ready=0 even when the slot is free.
  - The lock releases at the edge of an accept from lock_owner with req_lock[n]=0, or at reset.
  - last_grant still updates on each accept.
- Without it: the req_lock port and lock registers do not exist, and arbitration is pure round-robin.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then req_valid=00.
  - Required: rsp_valid=0, rsp_result=0, req_ready=00 throughout.
- Single request:
  - Stimulus: req0 src1=7, src2=5, control=001, rsp_ready=1.
  - Required: req_ready=01 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=2, rsp_zero=0.
- Tie and round-robin:
  - Stimulus: both valid for 4 cycles (req0: 3+4, control 000; req1: 9 AND 9, control 010), rsp_ready=1.
  - Required: responses id 0,1,0,1 with results 7,9,7,9 on consecutive cycles.
- Backpressure:
  - Stimulus: accept req1 slt 2<5, then rsp_ready=0 for 3 cycles with req0 valid.
  - Required: rsp_result=1 held steady, req_ready=00 for 3 cycles; req0 is accepted in the cycle rsp_ready returns to 1.
- Mid-operation reset:
  - Stimulus: rsp_valid=1, rsp_ready=0, then reset=1 for one cycle.
  - Required: rsp_valid=0 next cycle; with both valid afterwards, requester 0 is granted first.
- Lock (ALU_SHARE_LOCK_EN):
  - Stimulus: req1 with req_lock=10 for 3 accepts while req0 is valid, then req_lock=00.
  - Required: 3 responses with id=1, then id=1 once more (the unlock accept), then id=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready requesters.
// Requests are arbitrated round-robin. The ALU result and zero flag are captured in a
// one-entry response register that has its own valid/ready handshake.
// Optional feature macro: ALU_SHARE_LOCK_EN adds a req_lock input. A requester that
// sets req_lock when it is accepted keeps exclusive ownership of the ALU until it is
// accepted again with its lock bit clear.
module alu_share_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
`ifdef ALU_SHARE_LOCK_EN
   input  logic [1:0]        req_lock,
`endif
   input  logic [WIDTH-1:0]  req0_src1,
   input  logic [WIDTH-1:0]  req0_src2,
   input  logic [CTRL_W-1:0] req0_control,
   input  logic [WIDTH-1:0]  req1_src1,
   input  logic [WIDTH-1:0]  req1_src2,
   input  logic [CTRL_W-1:0] req1_control,
   output logic [WIDTH-1:0]  alu_src1,
   output logic [WIDTH-1:0]  alu_src2,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero
);

   logic       slot_free;
   logic [1:0] eligible;
   logic       grant_valid;
   logic       grant_id;
   logic       last_grant;
`ifdef ALU_SHARE_LOCK_EN
   logic       locked;
   logic       lock_owner;
`endif

   // A new response may be captured when the register is empty or drains this cycle
   assign slot_free = !rsp_valid || rsp_ready;

   // Requesters allowed to compete: every valid one, or only the lock owner while locked
   always_comb begin
      eligible = req_valid;
`ifdef ALU_SHARE_LOCK_EN
      if (locked) begin
         eligible = lock_owner ? (req_valid & 2'b10) : (req_valid & 2'b01);
      end else begin
         eligible = req_valid;
      end
`endif
   end

   // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (!reset && slot_free) begin
         case (eligible)
            2'b01: begin
               grant_valid = 1'b1;
               grant_id    = 1'b0;
            end
            2'b10: begin
               grant_valid = 1'b1;
               grant_id    = 1'b1;
            end
            2'b11: begin
               grant_valid = 1'b1;
               grant_id    = ~last_grant;
            end
            default: begin
               grant_valid = 1'b0;
               grant_id    = 1'b0;
            end
         endcase
      end else begin
         grant_valid = 1'b0;
         grant_id    = 1'b0;
      end
   end

   // Ready is one-hot on the granted requester and never depends on the payload
   always_comb begin
      req_ready = 2'b00;
      if (grant_valid) begin
         req_ready = grant_id ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Route the granted requester to the ALU; with no grant, requester 0 is routed so the drive is never X
   always_comb begin
      alu_src1    = req0_src1;
      alu_src2    = req0_src2;
      alu_control = req0_control;
      if (grant_valid && grant_id) begin
         alu_src1    = req1_src1;
         alu_src2    = req1_src2;
         alu_control = req1_control;
      end else begin
         alu_src1    = req0_src1;
         alu_src2    = req0_src2;
         alu_control = req0_control;
      end
   end

   // Response register: capture on accept, clear valid on a drain, hold otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= {WIDTH{1'b0}};
         rsp_zero   <= 1'b0;
         last_grant <= 1'b1;
      end else if (grant_valid) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= grant_id;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         last_grant <= grant_id;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

`ifdef ALU_SHARE_LOCK_EN
   // Lock ownership: taken by an accept with its lock bit set, released by the owner's accept with the bit clear
   always_ff @(posedge clk) begin
      if (reset) begin
         locked     <= 1'b0;
         lock_owner <= 1'b0;
      end else if (grant_valid) begin
         if (locked) begin
            if (!req_lock[grant_id]) begin
               locked <= 1'b0;
            end
         end else if (req_lock[grant_id]) begin
            locked     <= 1'b1;
            lock_owner <= grant_id;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. It runs directed scenarios and then randomized traffic.
// Every scenario is checked each cycle against a request-level reference model.
// Build with ALU_SHARE_LOCK_EN defined to exercise the lock feature.
module tb_alu_share_arbiter;
   localparam int WIDTH  = 32;
   localparam int CTRL_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
`ifdef ALU_SHARE_LOCK_EN
   logic [1:0]        req_lock;
`endif
   logic [WIDTH-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
   logic [CTRL_W-1:0] req0_control, req1_control;
   logic [WIDTH-1:0]  alu_src1, alu_src2, alu_result;
   logic [CTRL_W-1:0] alu_control;
   logic              alu_zero;
   logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [WIDTH-1:0]  rsp_result;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: contents of the response slot and arbitration history
   logic             m_valid, m_id, m_zero;
   logic [WIDTH-1:0] m_result;
   int               m_last, m_owner;
   bit               m_locked;
   logic [1:0]       acc_obs = 2'b00;

   always #5 clk = ~clk;

   // behavioural ALU, used both as the external ALU and to predict results
   function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [CTRL_W-1:0] c);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   assign alu_result = alu_ref(alu_src1, alu_src2, alu_control);
   assign alu_zero   = (alu_result == '0);

   alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
`ifdef ALU_SHARE_LOCK_EN
      .req_lock(req_lock),
`endif
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_control(req0_control),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_control(req1_control),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   // requesters must hold valid and payload until accepted
   assert property (@(posedge clk) disable iff (reset)
      (req_valid[0] && !req_ready[0]) |=> (req_valid[0] && $stable({req0_src1, req0_src2, req0_control})))
      else $error("FAIL req0_hold");
   assert property (@(posedge clk) disable iff (reset)
      (req_valid[1] && !req_ready[1]) |=> (req_valid[1] && $stable({req1_src1, req1_src2, req1_control})))
      else $error("FAIL req1_hold");

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // which requester the model grants this cycle, as a ready vector
   function automatic logic [1:0] model_ready();
      int cands[$];
      if (reset) return 2'b00;
      if (m_valid && !rsp_ready) return 2'b00;
      for (int n = 0; n < 2; n++)
         if (req_valid[n] && !(m_locked && m_owner != n)) cands.push_back(n);
      if (cands.size() == 0) return 2'b00;
      if (cands.size() == 1) return 2'b01 << cands[0];
      return 2'b01 << (1 - m_last);
   endfunction

   task automatic model_update(input logic [1:0] er);
      int n;
      if (reset) begin
         m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_zero = 1'b0;
         m_last = 1; m_locked = 1'b0; m_owner = 0;
      end else if (er != 2'b00) begin
         n = er[1] ? 1 : 0;
         m_valid  = 1'b1;
         m_id     = n[0];
         m_result = (n == 1) ? alu_ref(req1_src1, req1_src2, req1_control)
                             : alu_ref(req0_src1, req0_src2, req0_control);
         m_zero   = (m_result == '0);
         m_last   = n;
`ifdef ALU_SHARE_LOCK_EN
         if (m_locked) begin
            if (!req_lock[n]) m_locked = 1'b0;
         end else if (req_lock[n]) begin
            m_locked = 1'b1;
            m_owner  = n;
         end
`endif
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // one clock: compare on the falling edge, advance the model on the rising edge
   task automatic cycle();
      logic [1:0] er;
      bit g1;
      @(negedge clk);
      er = model_ready();
      g1 = (er == 2'b10);
      check_eq("req_ready", req_ready, er);
      check_eq("rsp_valid", rsp_valid, m_valid);
      check_eq("rsp_id", rsp_id, m_id);
      check_eq("rsp_result", rsp_result, m_result);
      check_eq("rsp_zero", rsp_zero, m_zero);
      check_eq("alu_src1", alu_src1, g1 ? req1_src1 : req0_src1);
      check_eq("alu_src2", alu_src2, g1 ? req1_src2 : req0_src2);
      check_eq("alu_control", alu_control, g1 ? req1_control : req0_control);
      acc_obs = req_valid & req_ready;
      @(posedge clk);
      model_update(er);
      #1;
   endtask

   task automatic set_req(input int n, input logic v, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [CTRL_W-1:0] c);
      if (n == 0) begin
         req_valid[0] = v; req0_src1 = a; req0_src2 = b; req0_control = c;
      end else begin
         req_valid[1] = v; req1_src1 = a; req1_src2 = b; req1_control = c;
      end
   endtask

   initial begin
      reset = 1'b1; rsp_ready = 1'b0; req_valid = 2'b00;
`ifdef ALU_SHARE_LOCK_EN
      req_lock = 2'b00;
`endif
      set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
      @(posedge clk); #1;
      model_update(2'b00);

      // reset then idle
      cycle(); cycle();
      reset = 1'b0;
      cycle(); cycle();
      check_eq("idle_valid", rsp_valid, 1'b0);
      check_eq("idle_result", rsp_result, 32'd0);

      // single request: 7 - 5
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'd7, 32'd5, 3'd1);
      cycle();
      check_eq("single_ready", acc_obs, 2'b01);
      req_valid[0] = 1'b0;
      check_eq("single_valid", rsp_valid, 1'b1);
      check_eq("single_id", rsp_id, 1'b0);
      check_eq("single_result", rsp_result, 32'd2);
      check_eq("single_zero", rsp_zero, 1'b0);
      cycle();

      // tie and round-robin, starting from reset
      reset = 1'b1; cycle(); reset = 1'b0;
      set_req(0, 1'b1, 32'd3, 32'd4, 3'd0);
      set_req(1, 1'b1, 32'd9, 32'd9, 3'd2);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check_eq("rr_id", rsp_id, k[0]);
         check_eq("rr_result", rsp_result, k[0] ? 32'd9 : 32'd7);
      end
      req_valid[1] = 1'b0;
      cycle();
      req_valid[0] = 1'b0;

      // backpressure: slt 2<5 held while the consumer stalls
      set_req(1, 1'b1, 32'd2, 32'd5, 3'd5);
      cycle();
      req_valid[1] = 1'b0;
      set_req(0, 1'b1, 32'd10, 32'd3, 3'd1);
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("bp_ready", acc_obs, 2'b00);
         check_eq("bp_result", rsp_result, 32'd1);
      end
      rsp_ready = 1'b1;
      cycle();
      check_eq("bp_accept", acc_obs, 2'b01);
      req_valid[0] = 1'b0;
      check_eq("bp_new_result", rsp_result, 32'd7);

      // reset while a response is stalled
      set_req(0, 1'b1, 32'd1, 32'd1, 3'd1);
      cycle();
      req_valid[0] = 1'b0;
      rsp_ready = 1'b0;
      cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      check_eq("rst_valid", rsp_valid, 1'b0);
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'd4, 32'd4, 3'd1);
      set_req(1, 1'b1, 32'd1, 32'd2, 3'd3);
      cycle();
      check_eq("rst_first", acc_obs, 2'b01);
      req_valid[0] = 1'b0;
      cycle();
      req_valid[1] = 1'b0;

`ifdef ALU_SHARE_LOCK_EN
      // lock: requester 1 owns the ALU for three accepts, then unlocks
      set_req(0, 1'b1, 32'd0, 32'd0, 3'd0);
      cycle();
      req_valid[0] = 1'b0;
      req_lock = 2'b10;
      set_req(0, 1'b1, 32'd5, 32'd6, 3'd0);
      set_req(1, 1'b1, 32'd8, 32'd8, 3'd1);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_eq("lock_id", rsp_id, 1'b1);
      end
      req_lock = 2'b00;
      cycle();
      check_eq("unlock_id", rsp_id, 1'b1);
      cycle();
      check_eq("after_unlock_id", rsp_id, 1'b0);
      req_valid[0] = 1'b0;
      cycle();
      req_valid[1] = 1'b0;
`endif

      // randomized traffic
      acc_obs = 2'b00;
      for (int i = 0; i < 600; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!req_valid[n] || acc_obs[n]) begin
               logic [WIDTH-1:0] a, b;
               a = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
               b = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
               set_req(n, ($urandom_range(0, 3) != 0), a, b, CTRL_W'($urandom_range(0, 7)));
`ifdef ALU_SHARE_LOCK_EN
               req_lock[n] = ($urandom_range(0, 3) == 0);
`endif
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
